// File: rtl/ram_arb_pkg.sv
// Shared defaults and helpers for the RAM port arbiter.
package ram_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_RD_LATENCY = 1;
  localparam int MAX_REQ        = 8;
  localparam int IDX_W          = 3;

  // Encode a one-hot (or all-zero) vector into a requester index.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic               found;
  logic [MAX_REQ-1:0] grant_ext;

  // Search upper half (>= ptr) first, then the wrapped lower half (< ptr).
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (i < int'(ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  // Index of the winner; zero when nothing is granted.
  always_comb begin
    grant_ext              = '0;
    grant_ext[NUM_REQ-1:0] = grant;
    idx                    = onehot_to_idx(grant_ext);
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one read port and one write port of a RAM among NUM_REQ requesters.
// Handshake: requester i's op is accepted at a rising clk edge when
// req_valid[i] & req_ready[i]; ready is a same-cycle combinational grant and
// a requester may drop valid while ungranted. Read data comes back RD_LATENCY
// cycles after acceptance with a one-hot rsp_valid naming the requester.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          idle,
  output logic [ADDR_WIDTH-1:0]         ram_raddr_0,
  input  logic [DATA_WIDTH-1:0]         ram_rdata_0,
  output logic [ADDR_WIDTH-1:0]         ram_waddr_0,
  output logic                          ram_wen_0,
  output logic [DATA_WIDTH-1:0]         ram_wdata_0
);

  logic [NUM_REQ-1:0] rd_req;
  logic [NUM_REQ-1:0] wr_req;
  logic [NUM_REQ-1:0] rd_grant;
  logic [NUM_REQ-1:0] wr_grant;
  logic [IDX_W-1:0]   rd_idx;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [NUM_REQ-1:0] tag_q [RD_LATENCY];
  logic [NUM_REQ-1:0] tag_d [RD_LATENCY];
  logic               tag_any;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] cur);
    return (int'(cur) == NUM_REQ - 1) ? '0 : cur + 1'b1;
  endfunction

  // Split requests by direction; while reset is held nothing may be granted.
  always_comb begin
    rd_req = {NUM_REQ{rst}} & req_valid & ~req_we;
    wr_req = {NUM_REQ{rst}} & req_valid & req_we;
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
    .req   (rd_req),
    .ptr   (rd_ptr_q),
    .grant (rd_grant),
    .idx   (rd_idx)
  );

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
    .req   (wr_req),
    .ptr   (wr_ptr_q),
    .grant (wr_grant),
    .idx   (wr_idx)
  );

  // Steer the winners' address/data onto the RAM ports; zeros when idle.
  always_comb begin
    ram_raddr_0 = '0;
    ram_waddr_0 = '0;
    ram_wdata_0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rd_grant[i]) ram_raddr_0 = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (wr_grant[i]) begin
        ram_waddr_0 = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram_wdata_0 = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    ram_wen_0 = |wr_grant;
    req_ready = rd_grant | wr_grant;
  end

  // Next pointers and next tag pipeline contents.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (|rd_grant) rd_ptr_d = next_ptr(rd_idx);
    if (|wr_grant) wr_ptr_d = next_ptr(wr_idx);
    tag_d[0] = rd_grant;
    for (int k = 1; k < RD_LATENCY; k++) begin
      tag_d[k] = tag_q[k-1];
    end
  end

  // Pointer and tag registers; reset discards every read in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int k = 0; k < RD_LATENCY; k++) tag_q[k] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      for (int k = 0; k < RD_LATENCY; k++) tag_q[k] <= tag_d[k];
    end
  end

  // Response side and idle detection.
  always_comb begin
    tag_any = 1'b0;
    for (int k = 0; k < RD_LATENCY; k++) begin
      tag_any = tag_any | (|tag_q[k]);
    end
    rsp_valid = tag_q[RD_LATENCY-1];
    rsp_rdata = ram_rdata_0;
    idle      = ~rst | (~|req_valid & ~tag_any);
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: one arbiter with read latency 1 and one with latency 3,
// driven by the same requests, each with its own RAM read pipeline.
module tb_ram_port_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;

  logic [1:0]  rdy1, rv1, rdy3, rv3;
  logic [31:0] rd1, rd3, wdata1, wdata3, rdata1, rdata3;
  logic        idle1, idle3, wen1, wen3;
  logic [15:0] raddr1, waddr1, raddr3, waddr3;

  logic [31:0] mem [256];
  logic [31:0] rp1;
  logic [31:0] rp3 [3];

  int vectors;
  int errors;

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  ram_port_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(16), .DATA_WIDTH(32), .RD_LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(rdy1), .rsp_valid(rv1), .rsp_rdata(rd1), .idle(idle1),
    .ram_raddr_0(raddr1), .ram_rdata_0(rdata1), .ram_waddr_0(waddr1), .ram_wen_0(wen1),
    .ram_wdata_0(wdata1)
  );

  ram_port_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(16), .DATA_WIDTH(32), .RD_LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(rdy3), .rsp_valid(rv3), .rsp_rdata(rd3), .idle(idle3),
    .ram_raddr_0(raddr3), .ram_rdata_0(rdata3), .ram_waddr_0(waddr3), .ram_wen_0(wen3),
    .ram_wdata_0(wdata3)
  );

  // RAM model: synchronous read (old data on same-cycle write), writes from u1.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[1] = 32'h0000_1111;
    mem[2] = 32'h0000_2222;
  end

  always @(posedge clk) begin
    rp1    <= mem[raddr1[7:0]];
    rp3[0] <= mem[raddr3[7:0]];
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
    if (wen1) mem[waddr1[7:0]] <= wdata1;
  end

  assign rdata1 = rp1;
  assign rdata3 = rp3[2];

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [15:0] a0,
                       input logic [15:0] a1, input logic [31:0] d0, input logic [31:0] d1);
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  // Scoreboard check
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst     = 1'b0;
    drive(2'b00, 2'b00, 16'd0, 16'd0, 32'd0, 32'd0);

    // Reset state, then requests while reset held
    #3;
    chk("rst_ready", 64'(rdy1), 64'h0);
    chk("rst_rsp", 64'(rv1), 64'h0);
    chk("rst_wen", 64'(wen1), 64'h0);
    chk("rst_idle", 64'(idle1), 64'h1);
    chk("rst_rsp3", 64'(rv3), 64'h0);
    drive(2'b11, 2'b01, 16'd1, 16'd2, 32'h55, 32'd0);
    #1;
    chk("rst_busy_ready", 64'(rdy1), 64'h0);
    chk("rst_busy_wen", 64'(wen1), 64'h0);
    chk("rst_busy_idle", 64'(idle1), 64'h1);
    drive(2'b00, 2'b00, 16'd0, 16'd0, 32'd0, 32'd0);
    cyc();
    cyc();
    rst = 1'b1;

    // Read contention: grants alternate, data one cycle later (three on u3)
    drive(2'b11, 2'b00, 16'd1, 16'd2, 32'd0, 32'd0);
    #3;
    chk("ct1_ready", 64'(rdy1), 64'h1);
    chk("ct1_raddr", 64'(raddr1), 64'h1);
    chk("ct1_idle", 64'(idle1), 64'h0);
    cyc(); #3;
    chk("ct2_ready", 64'(rdy1), 64'h2);
    chk("ct2_raddr", 64'(raddr1), 64'h2);
    chk("ct2_rsp", 64'(rv1), 64'h1);
    chk("ct2_rdata", 64'(rd1), 64'h1111);
    cyc(); #3;
    chk("ct3_ready", 64'(rdy1), 64'h1);
    chk("ct3_rsp", 64'(rv1), 64'h2);
    chk("ct3_rdata", 64'(rd1), 64'h2222);
    chk("ct3_rsp3", 64'(rv3), 64'h0);
    cyc(); #3;
    chk("ct4_ready", 64'(rdy1), 64'h2);
    chk("ct4_rsp", 64'(rv1), 64'h1);
    chk("ct4_rsp3", 64'(rv3), 64'h1);
    chk("ct4_rdata3", 64'(rd3), 64'h1111);
    cyc();
    drive(2'b00, 2'b00, 16'd0, 16'd0, 32'd0, 32'd0);
    #3;
    chk("ct5_rsp", 64'(rv1), 64'h2);
    chk("ct5_rdata", 64'(rd1), 64'h2222);
    chk("ct5_rsp3", 64'(rv3), 64'h2);
    chk("ct5_rdata3", 64'(rd3), 64'h2222);
    cyc(); #3;
    chk("ct6_rsp", 64'(rv1), 64'h0);
    chk("ct6_rsp3", 64'(rv3), 64'h1);
    cyc(); #3;
    chk("ct7_rsp3", 64'(rv3), 64'h2);
    cyc(); #3;
    chk("ct8_rsp3", 64'(rv3), 64'h0);
    chk("ct8_idle", 64'(idle1), 64'h1);
    chk("ct8_idle3", 64'(idle3), 64'h1);

    // Single write then read back
    cyc();
    drive(2'b01, 2'b01, 16'd5, 16'd0, 32'hCAFE, 32'd0);
    #3;
    chk("wr_ready", 64'(rdy1), 64'h1);
    chk("wr_wen", 64'(wen1), 64'h1);
    chk("wr_waddr", 64'(waddr1), 64'h5);
    chk("wr_wdata", 64'(wdata1), 64'hCAFE);
    chk("wr_raddr_idle", 64'(raddr1), 64'h0);
    chk("wr_wen3", 64'(wen3), 64'h1);
    chk("wr_waddr3", 64'({waddr3, wdata3}), 64'h5_0000_CAFE);
    cyc();
    drive(2'b01, 2'b00, 16'd5, 16'd0, 32'd0, 32'd0);
    #3;
    chk("rd_ready", 64'(rdy1), 64'h1);
    chk("rd_raddr", 64'(raddr1), 64'h5);
    chk("rd_wen_off", 64'(wen1), 64'h0);
    chk("rd_waddr_zero", 64'({waddr1, wdata1}), 64'h0);
    cyc();
    drive(2'b00, 2'b00, 16'd0, 16'd0, 32'd0, 32'd0);
    #3;
    chk("rd_rsp", 64'(rv1), 64'h1);
    chk("rd_rdata", 64'(rd1), 64'hCAFE);
    cyc();
    cyc(); #3;
    chk("rd_rsp3", 64'(rv3), 64'h1);
    chk("rd_rdata3", 64'(rd3), 64'hCAFE);

    // Write contention: wr pointer sits at 1, so requester 1 wins first
    cyc();
    drive(2'b11, 2'b11, 16'd8, 16'd9, 32'h8888, 32'h9999);
    #3;
    chk("wc1_ready", 64'(rdy1), 64'h2);
    chk("wc1_waddr", 64'(waddr1), 64'h9);
    chk("wc1_wdata", 64'(wdata1), 64'h9999);
    cyc(); #3;
    chk("wc2_ready", 64'(rdy1), 64'h1);
    chk("wc2_waddr", 64'(waddr1), 64'h8);

    // Concurrent write (req0) and read (req1) of address 7
    cyc();
    drive(2'b11, 2'b01, 16'd7, 16'd7, 32'hBEEF, 32'd0);
    #3;
    chk("cc_ready", 64'(rdy1), 64'h3);
    chk("cc_wen", 64'(wen1), 64'h1);
    chk("cc_addrs", 64'({raddr1, waddr1}), 64'h0007_0007);
    cyc();
    drive(2'b10, 2'b00, 16'd0, 16'd7, 32'd0, 32'd0);
    #3;
    chk("cc_rsp_old", 64'(rv1), 64'h2);
    chk("cc_rdata_old", 64'(rd1), 64'h0);
    chk("cc_ready2", 64'(rdy1), 64'h2);
    cyc();
    drive(2'b00, 2'b00, 16'd0, 16'd0, 32'd0, 32'd0);
    #3;
    chk("cc_rsp_new", 64'(rv1), 64'h2);
    chk("cc_rdata_new", 64'(rd1), 64'hBEEF);
    cyc();
    cyc();
    cyc();

    // Reset during a read: no response, pointer back at 0
    drive(2'b01, 2'b00, 16'd2, 16'd0, 32'd0, 32'd0);
    #3;
    chk("mr_ready", 64'(rdy1), 64'h1);
    cyc();
    rst = 1'b0;
    drive(2'b00, 2'b00, 16'd0, 16'd0, 32'd0, 32'd0);
    #1;
    chk("mr_rsp", 64'(rv1), 64'h0);
    chk("mr_rsp3_a", 64'(rv3), 64'h0);
    cyc(); #3;
    chk("mr_rsp3_b", 64'(rv3), 64'h0);
    cyc(); #3;
    chk("mr_rsp3_c", 64'(rv3), 64'h0);
    chk("mr_idle", 64'(idle1), 64'h1);
    cyc();
    rst = 1'b1;
    drive(2'b11, 2'b00, 16'd1, 16'd2, 32'd0, 32'd0);
    #3;
    chk("mr_ptr", 64'(rdy1), 64'h1);
    chk("mr_ptr3", 64'(rdy3), 64'h1);
    chk("mr_rsp_after", 64'(rv1), 64'h0);
    cyc();
    drive(2'b00, 2'b00, 16'd0, 16'd0, 32'd0, 32'd0);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
